// File: rtl/crc32_stream_if.sv
// Stream-in / result-out bundle for the CRC32 frame controller.
// The slave modport is the controller's view; the master modport is the source/consumer side.
interface crc32_stream_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_sop;
    logic             in_eop;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_crc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_crc, out_count, out_ovf
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_crc, out_count, out_ovf
    );
endinterface

// File: rtl/crc32_stream_ctrl.sv
// Frame controller: folds a valid/ready stream of 32-bit words into a running CRC32
// (poly 0x04C11DB7, word MSB first) and holds the per-frame result until it is taken.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no frame open; next accepted word always starts a frame
// S_ACCUM | frame open, accumulating; sop restarts, eop closes
// S_DONE  | result presented on out_*, input stalled until out_ready
module crc32_stream_ctrl #(
    parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] XOROUT = 32'h0000_0000,
    parameter int          CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    crc32_stream_if.slave  bus,
    output logic           busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [31:0]      POLY    = 32'h04C1_1DB7;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [31:0] crc32_word(input logic [31:0] data,
                                               input logic [31:0] seed);
        logic [31:0] c;
        logic        fb;
        c = seed;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [31:0]      crc_q,       crc_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_crc_q,   out_crc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q,   out_ovf_d;

    logic        in_ready;
    logic        accept;
    logic        start;
    logic [31:0] crc_next;

    assign in_ready = (state_q != S_DONE);
    assign accept   = bus.in_valid & in_ready;
    // Any word taken in IDLE opens a frame; an sop inside a frame discards the partial one.
    assign start    = (state_q == S_IDLE) | ((state_q == S_ACCUM) & bus.in_sop);
    assign crc_next = crc32_word(bus.in_data, start ? INIT : crc_q);

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_crc_d   = out_crc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            crc_d = crc_next;
            if (start) begin
                count_d = {{(CNT_W-1){1'b0}}, 1'b1};
                ovf_d   = 1'b0;
            end else if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end

            if (bus.in_eop) begin
                state_d     = S_DONE;
                out_valid_d = 1'b1;
                out_crc_d   = crc_next ^ XOROUT;
                out_count_d = count_d;
                out_ovf_d   = ovf_d;
            end else begin
                state_d = S_ACCUM;
            end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            crc_d       = INIT;
            count_d     = '0;
            ovf_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crc_q       <= INIT;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_crc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_crc_q   <= out_crc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_crc   = out_crc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
    assign busy          = (state_q != S_IDLE);

endmodule
